// File: rtl/nibble_class_sched.sv
// nibble_class_sched: two-requester round-robin front end for the shared
// 4-bit prime / divisible-by-3 classifier. Scans the granted word one
// nibble per cycle, LSB first, and reports per-nibble masks and counts.
module nibble_class_sched #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [1:0]                     req,
    input  logic [4*NIBBLES-1:0]           data0,
    input  logic [4*NIBBLES-1:0]           data1,
    output logic [1:0]                     gnt,
    output logic                           busy,
    output logic                           done,
    output logic                           done_id,
    output logic [NIBBLES-1:0]             prime_mask,
    output logic [NIBBLES-1:0]             div3_mask,
    output logic [$clog2(NIBBLES+1)-1:0]   prime_cnt,
    output logic [$clog2(NIBBLES+1)-1:0]   div3_cnt
);

    localparam int unsigned W        = 4 * NIBBLES;
    localparam int unsigned CW       = $clog2(NIBBLES + 1);
    localparam int unsigned IW       = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [W-1:0]        shreg, shreg_nxt;
    logic [IW-1:0]       idx, idx_nxt;
    logic [NIBBLES-1:0]  acc_prime, acc_prime_nxt;
    logic [NIBBLES-1:0]  acc_div3, acc_div3_nxt;
    logic [CW-1:0]       acc_pcnt, acc_pcnt_nxt;
    logic [CW-1:0]       acc_dcnt, acc_dcnt_nxt;
    logic                last_served, last_served_nxt;
    logic                winner, winner_nxt;
    logic                win_c;
    logic                is_prime_c;
    logic                is_div3_c;

    logic [1:0]          gnt_nxt;
    logic                busy_nxt;
    logic                done_nxt;
    logic                done_id_nxt;
    logic [NIBBLES-1:0]  prime_mask_nxt;
    logic [NIBBLES-1:0]  div3_mask_nxt;
    logic [CW-1:0]       prime_cnt_nxt;
    logic [CW-1:0]       div3_cnt_nxt;

    // Classify the nibble currently at the bottom of the shift register
    always_comb begin
        is_prime_c = 1'b0;
        is_div3_c  = 1'b0;
        unique case (shreg[3:0])
            4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: is_prime_c = 1'b1;
            default:                              is_prime_c = 1'b0;
        endcase
        unique case (shreg[3:0])
            4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15: is_div3_c = 1'b1;
            default:                              is_div3_c = 1'b0;
        endcase
    end

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        win_c = 1'b0;
        if (req == 2'b10) begin
            win_c = 1'b1;
        end else if (req == 2'b11) begin
            win_c = ~last_served;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt       = state;
        shreg_nxt       = shreg;
        idx_nxt         = idx;
        acc_prime_nxt   = acc_prime;
        acc_div3_nxt    = acc_div3;
        acc_pcnt_nxt    = acc_pcnt;
        acc_dcnt_nxt    = acc_dcnt;
        last_served_nxt = last_served;
        winner_nxt      = winner;
        gnt_nxt         = gnt;
        busy_nxt        = busy;
        done_nxt        = 1'b0;
        done_id_nxt     = done_id;
        prime_mask_nxt  = prime_mask;
        div3_mask_nxt   = div3_mask;
        prime_cnt_nxt   = prime_cnt;
        div3_cnt_nxt    = div3_cnt;

        unique case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    state_nxt       = SCAN;
                    shreg_nxt       = win_c ? data1 : data0;
                    idx_nxt         = '0;
                    acc_prime_nxt   = '0;
                    acc_div3_nxt    = '0;
                    acc_pcnt_nxt    = '0;
                    acc_dcnt_nxt    = '0;
                    last_served_nxt = win_c;
                    winner_nxt      = win_c;
                    gnt_nxt         = win_c ? 2'b10 : 2'b01;
                    busy_nxt        = 1'b1;
                end
            end
            SCAN: begin
                acc_prime_nxt = acc_prime | (NIBBLES'(is_prime_c) << idx);
                acc_div3_nxt  = acc_div3  | (NIBBLES'(is_div3_c)  << idx);
                acc_pcnt_nxt  = acc_pcnt + CW'(is_prime_c);
                acc_dcnt_nxt  = acc_dcnt + CW'(is_div3_c);
                shreg_nxt     = shreg >> 4;
                idx_nxt       = idx + IW'(1);
                if (idx == LAST_IDX) begin
                    // Results are loaded on the edge into DONE so they are
                    // already visible in the cycle that carries the pulse.
                    state_nxt      = DONE;
                    gnt_nxt        = 2'b00;
                    done_nxt       = 1'b1;
                    done_id_nxt    = winner;
                    prime_mask_nxt = acc_prime_nxt;
                    div3_mask_nxt  = acc_div3_nxt;
                    prime_cnt_nxt  = acc_pcnt_nxt;
                    div3_cnt_nxt   = acc_dcnt_nxt;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 2'b00;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            idx         <= '0;
            acc_prime   <= '0;
            acc_div3    <= '0;
            acc_pcnt    <= '0;
            acc_dcnt    <= '0;
            last_served <= 1'b1;
            winner      <= 1'b0;
            gnt         <= 2'b00;
            busy        <= 1'b0;
            done        <= 1'b0;
            done_id     <= 1'b0;
            prime_mask  <= '0;
            div3_mask   <= '0;
            prime_cnt   <= '0;
            div3_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            shreg       <= shreg_nxt;
            idx         <= idx_nxt;
            acc_prime   <= acc_prime_nxt;
            acc_div3    <= acc_div3_nxt;
            acc_pcnt    <= acc_pcnt_nxt;
            acc_dcnt    <= acc_dcnt_nxt;
            last_served <= last_served_nxt;
            winner      <= winner_nxt;
            gnt         <= gnt_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            done_id     <= done_id_nxt;
            prime_mask  <= prime_mask_nxt;
            div3_mask   <= div3_mask_nxt;
            prime_cnt   <= prime_cnt_nxt;
            div3_cnt    <= div3_cnt_nxt;
        end
    end

endmodule

// File: doc/nibble_class_sched.md
# nibble_class_sched

Two-requester scheduler for the shared 4-bit nibble classifier (prime / divisible-by-3). It round-robin arbitrates between two requesters and captures the winner's word. It then sequences the word through the classifier one nibble per cycle, LSB nibble first, and returns per-nibble flag masks plus flag counts with a one-cycle done pulse. It sits between the requester clients and the classifier datapath.

## Interface
- NIBBLES, default 4: nibbles per word. The word width is 4*NIBBLES. Legal range is 1..8.
- clk, input, 1: single clock. All state updates on the rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- req, input, 2: request per requester. req[i] is held high until done with done_id==i.
- data0, input, 4*NIBBLES: word from requester 0. Sampled only in the grant cycle.
- data1, input, 4*NIBBLES: word from requester 1. Sampled only in the grant cycle.
- gnt, output, 2: one-hot grant. High for the whole scan of the granted job.
- busy, output, 1: high while a job is in SCAN or DONE.
- done, output, 1: one-cycle pulse. Results are valid from this cycle.
- done_id, output, 1: requester served by the current or last done.
- prime_mask, output, NIBBLES: bit k is set when nibble k ∈ {2,3,5,7,11,13}.
- div3_mask, output, NIBBLES: bit k is set when nibble k ∈ {0,3,6,9,12,15}. 0 counts as divisible.
- prime_cnt, output, $clog2(NIBBLES+1): popcount of prime_mask.
- div3_cnt, output, $clog2(NIBBLES+1): popcount of div3_mask.

## Operation
- FSM states are IDLE, SCAN and DONE.
- **IDLE**
  - If req==0, stay in IDLE.
  - Otherwise pick a winner, then go to SCAN. In the same edge:
    - load the shift register with the winner's data
    - clear idx, accumulator masks and counts
    - set gnt to one-hot of the winner
- **Arbitration**
  - With a single request, that requester wins.
  - With both requesting, the winner is the one not served last.
  - The last-served pointer resets to 1, so requester 0 wins the first tie.
  - The pointer updates when the grant is taken.
- **SCAN**, one cycle per nibble:
  - classify shreg[3:0]
  - set accumulator mask bit idx for each flag that is true
  - add the flag bits to the counts
  - shift shreg right by 4 and increment idx
  - when idx==NIBBLES-1 is processed, go to DONE
- **DONE**, one cycle:
  - copy the accumulators into the output registers
  - done=1, done_id=winner, gnt=0, busy=1
  - next state is IDLE
- Output masks, counts and done_id hold their last values until the next DONE. They are never updated mid-scan.
- req dropping during SCAN is ignored: the job completes and done is still issued.
- req changing during SCAN does not change gnt.
- Counts cannot overflow: the width covers NIBBLES.
- Classification is purely combinational on the current nibble, with no pipelining inside.

## Timing
- Reset: on a clk edge with rst_n=0:
  - state=IDLE
  - gnt=0, busy=0, done=0, done_id=0
  - masks=0, counts=0
  - pointer=1
- Reset mid-SCAN or in DONE aborts the job, with no done pulse. Reset dominates every other event on the same edge.
- req first seen high in IDLE at edge T:
  - gnt and busy are high from cycle T+1.
  - SCAN occupies cycles T+1 .. T+NIBBLES.
  - done, with results, is high in cycle T+NIBBLES+1.
  - gnt is low in cycle T+NIBBLES+1.
  - IDLE returns at T+NIBBLES+2.
- A new request is sampled no earlier than edge T+NIBBLES+2. Throughput is one job per NIBBLES+2 cycles.
- A requester still holding req in IDLE after its done is treated as a new request. It loses a tie to the other requester.

## Test plan
- Reset, then req=01, data0=0x3D72 (nibbles 2,7,D,3):
  - done in cycle 5 after the grant edge
  - prime_mask=1111, prime_cnt=4
  - div3_mask=1000, div3_cnt=1
  - done_id=0
- Both req high from the same edge:
  - data0=0x3D72, data1=0x0C96 (nibbles 6,9,C,0)
  - first done_id=0
  - second done_id=1, with prime_mask=0000, div3_mask=1111, div3_cnt=4
  - gnt sequence is 01 then 10
- Both req held continuously for 4 jobs:
  - grants alternate 0,1,0,1
  - done spaced exactly 6 cycles apart (NIBBLES=4)
  - gnt is never two-hot
- req=01, data0=0x8E41 (nibbles 1,4,E,8):
  - all masks and counts are 0, and done is still pulsed
  - then req1 with 0xFFFF: div3_mask=1111, prime_mask=0000
- Drop req0 in the second SCAN cycle: the job completes with correct results and done_id=0.
- Assert rst_n=0 for one cycle in the third SCAN cycle:
  - next cycle all outputs are 0 and state is IDLE, with no done
  - the held req0 is then re-served normally with correct results
